// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-latch enable/flush from memory wait, branch,
// load-use and fetch-miss conditions. Optional stall counter under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int NSTAGES  = 5,
  parameter int REGW     = 5,
  parameter int BR_LATCH = 2,
  parameter int CNTW     = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ihit,
  input  logic                 dhit,
  input  logic                 dmem_req_mem,
  input  logic                 memread_ex,
  input  logic [REGW-1:0]      rd_ex,
  input  logic [REGW-1:0]      rs_id,
  input  logic [REGW-1:0]      rt_id,
  input  logic                 branch_mem,
  input  logic                 halt_wb,
  output logic [NSTAGES-2:0]   enable,
  output logic [NSTAGES-2:0]   flush,
  output logic                 halt,
  output logic [CNTW-1:0]      stall_cnt
);

  localparam int L = NSTAGES - 1;
  localparam logic [L-1:0] BR_MASK     = {L{1'b1}} >> (L - 1 - BR_LATCH);
  localparam logic [L-1:0] BUBBLE_EN   = {{(L-1){1'b1}}, 1'b0};
  localparam logic [L-1:0] BUBBLE_FL   = {{(L-2){1'b0}}, 2'b10};

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_e;

  state_e state_q, state_d;
  logic   halt_q, halt_d;
  logic   memok;
  logic   load_use;

  // Once waiting on data memory, only dhit releases the freeze.
  assign memok    = (state_q == DWAIT) ? dhit : (!dmem_req_mem || dhit);
  assign load_use = memread_ex && (rd_ex != '0) && ((rd_ex == rs_id) || (rd_ex == rt_id));

  always_comb begin
    enable = '0;
    flush  = '0;
    if (RST) begin
      flush = '1;
    end else if (state_q == HALTED || !memok) begin
      enable = '0;
    end else if (branch_mem) begin
      enable = '1;
      flush  = BR_MASK;
    end else if (load_use || !ihit) begin
      enable = BUBBLE_EN;
      flush  = BUBBLE_FL;
    end else begin
      enable = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_wb && memok)               state_d = HALTED;
        else if (dmem_req_mem && !dhit)     state_d = DWAIT;
      end
      DWAIT: begin
        if (halt_wb && memok)               state_d = HALTED;
        else if (dhit)                      state_d = RUN;
      end
      HALTED:                               state_d = HALTED;
      default:                              state_d = RUN;
    endcase
    halt_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign halt = halt_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != HALTED && !enable[0] && cnt_q != '1)
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks plus randomized traffic compared
// every cycle against a flag-based behavioural model.
module tb_hazard_ctrl;
  localparam int NST = 5;
  localparam int L   = NST - 1;
  localparam int RW  = 5;
  localparam int BRL = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ihit = 1'b1, dhit = 1'b0, dmem_req_mem = 1'b0, memread_ex = 1'b0;
  logic [RW-1:0] rd_ex = '0, rs_id = '0, rt_id = '0;
  logic          branch_mem = 1'b0, halt_wb = 1'b0;
  logic [L-1:0]  enable, flush, enable4, flush4;
  logic          halt, halt4;
  logic [31:0]   stall_cnt;
  logic [3:0]    stall_cnt4;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  armed  = 0;

  bit     m_halt = 0;
  bit     m_wait = 0;
  longint m_cnt  = 0;
  longint m_cnt4 = 0;

  hazard_ctrl #(.NSTAGES(NST), .REGW(RW), .BR_LATCH(BRL), .CNTW(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req_mem(dmem_req_mem),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .branch_mem(branch_mem), .halt_wb(halt_wb), .enable(enable), .flush(flush),
    .halt(halt), .stall_cnt(stall_cnt));

  hazard_ctrl #(.NSTAGES(NST), .REGW(RW), .BR_LATCH(BRL), .CNTW(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req_mem(dmem_req_mem),
    .memread_ex(memread_ex), .rd_ex(rd_ex), .rs_id(rs_id), .rt_id(rt_id),
    .branch_mem(branch_mem), .halt_wb(halt_wb), .enable(enable4), .flush(flush4),
    .halt(halt4), .stall_cnt(stall_cnt4));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_memok();
    return m_wait ? dhit : (!dmem_req_mem || dhit);
  endfunction

  // Outputs straight from the priority list: reset, halted, mem stall, branch, bubble, run.
  function automatic void model_out(output logic [L-1:0] en, output logic [L-1:0] fl);
    bit lu;
    lu = memread_ex && rd_ex != 0 && (rd_ex == rs_id || rd_ex == rt_id);
    en = '0;
    fl = '0;
    if (RST)                        fl = '1;
    else if (m_halt || !model_memok()) en = '0;
    else if (branch_mem) begin      en = '1; fl = L'((1 << (BRL + 1)) - 1); end
    else if (lu || !ihit) begin     en = L'((1 << L) - 2); fl = L'(2); end
    else                            en = '1;
  endfunction

  always @(posedge CLK) begin
    logic [L-1:0] en, fl;
    bit mok;
    model_out(en, fl);
    mok = model_memok();
`ifdef HAZARD_PERF_CNT_EN
    if (RST) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (!m_halt && !en[0]) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
`endif
    if (RST) begin
      m_halt = 0; m_wait = 0;
    end else if (!m_halt) begin
      if (halt_wb && mok) begin m_halt = 1; m_wait = 0; end
      else if (m_wait)    m_wait = !dhit;
      else                m_wait = dmem_req_mem && !dhit;
    end
    armed = 1;
  end

  always @(negedge CLK) begin
    logic [L-1:0] en, fl;
    if (armed) begin
      model_out(en, fl);
      check("model enable", enable, en);
      check("model flush", flush, fl);
      check("model halt", halt, m_halt);
      check("model stall_cnt", stall_cnt, m_cnt);
      check("model stall_cnt4", stall_cnt4, m_cnt4);
      check("cntw4 enable", enable4, en);
      check("cntw4 flush", flush4, fl);
      check("cntw4 halt", halt4, m_halt);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; dmem_req_mem = 0; memread_ex = 0;
    rd_ex = 0; rs_id = 0; rt_id = 0; branch_mem = 0; halt_wb = 0;
  endtask

  task automatic do_reset();
    RST = 1; idle();
    tick();
    RST = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    tick();
    @(negedge CLK);
    check("reset enable", enable, 4'b0000);
    check("reset flush", flush, 4'b1111);
    check("reset halt", halt, 0);
    tick();
    RST = 0;

    memread_ex = 1; rd_ex = 5; rs_id = 5; rt_id = 0; ihit = 1;
    @(negedge CLK);
    check("loaduse enable", enable, 4'b1110);
    check("loaduse flush", flush, 4'b0010);
    tick();
    rd_ex = 0; rs_id = 0;
    @(negedge CLK);
    check("rd0 enable", enable, 4'b1111);
    check("rd0 flush", flush, 4'b0000);
    tick();

    memread_ex = 1; rd_ex = 7; rt_id = 7; ihit = 0; branch_mem = 1;
    @(negedge CLK);
    check("branch enable", enable, 4'b1111);
    check("branch flush", flush, 4'b0111);
    tick();
    idle();

    dmem_req_mem = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("dwait frozen", enable, 4'b0000);
      check("dwait no flush", flush, 4'b0000);
      tick();
    end
    dmem_req_mem = 0;
    @(negedge CLK);
    check("dwait holds without req", enable, 4'b0000);
    tick();
    dmem_req_mem = 1; dhit = 1;
    @(negedge CLK);
    check("dhit release", enable, 4'b1111);
    tick();
    idle();
    @(negedge CLK);
    check("run after dhit", enable, 4'b1111);
    tick();

    dhit = 1;
    tick();
    dhit = 0;
    @(negedge CLK);
    check("stray dhit ignored", enable, 4'b1111);
    tick();

    halt_wb = 1;
    @(negedge CLK);
    check("halt not yet", halt, 0);
    tick();
    halt_wb = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("halted flag", halt, 1);
      check("halted enable", enable, 4'b0000);
      check("halted flush", flush, 4'b0000);
      tick();
    end
    do_reset();
    @(negedge CLK);
    check("post halt reset halt", halt, 0);
    check("post halt reset enable", enable, 4'b1111);
    tick();

    dmem_req_mem = 1; dhit = 0;
    tick();
    do_reset();
    @(negedge CLK);
    check("reset out of dwait", enable, 4'b1111);
    tick();

    do_reset();
    ihit = 0;
    repeat (10) tick();
    @(negedge CLK);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt 10", stall_cnt, 10);
    check("stall_cnt4 10", stall_cnt4, 10);
`else
    check("stall_cnt off", stall_cnt, 0);
    check("stall_cnt4 off", stall_cnt4, 0);
`endif
    repeat (10) tick();
    @(negedge CLK);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt 20", stall_cnt, 20);
    check("stall_cnt4 sat", stall_cnt4, 15);
`else
    check("stall_cnt off late", stall_cnt, 0);
`endif
    tick();
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      RST          = ($urandom_range(0, 99) < 2);
      ihit         = ($urandom_range(0, 99) < 80);
      dmem_req_mem = ($urandom_range(0, 99) < 30);
      dhit         = ($urandom_range(0, 99) < 50);
      memread_ex   = ($urandom_range(0, 99) < 35);
      rd_ex        = RW'($urandom_range(0, 3));
      rs_id        = RW'($urandom_range(0, 3));
      rt_id        = RW'($urandom_range(0, 3));
      branch_mem   = ($urandom_range(0, 99) < 12);
      halt_wb      = ($urandom_range(0, 99) < 3);
      tick();
    end
    RST = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NSTAGES, default 5, pipeline stage count (min 4); latch count L = NSTAGES-1, latch i sits between stage i and i+1.
REQ-002 Parameter REGW, default 5, register-address width.
REQ-003 Parameter BR_LATCH, default 2, highest latch index flushed on a taken branch (must be < L-1).
REQ-004 Parameter CNTW, default 32, stall-counter width.
REQ-005 Clocking SHALL be one clock, CLK; reset SHALL be RST, synchronous and active-high.
REQ-006 Ports SHALL be, as name  direction  width  meaning:
- CLK  in  1  clock
- RST  in  1  sync active-high reset
- ihit  in  1  instruction fetch satisfied this cycle
- dhit  in  1  data access satisfied this cycle
- dmem_req_mem  in  1  load/store in MEM stage
- memread_ex  in  1  load in EX stage
- rd_ex  in  REGW  EX-stage destination register
- rs_id, rt_id  in  REGW each  ID-stage source registers
- branch_mem  in  1  taken branch/jump resolved in MEM
- halt_wb  in  1  halt instruction in WB
- enable  out  L  per-latch update enable
- flush  out  L  per-latch clear; dominates enable inside latch
- halt  out  1  sticky halted flag
- stall_cnt  out  CNTW  front-end stall cycles

Function
REQ-007 FSM states SHALL be RUN, DWAIT, HALTED; reset state RUN.
REQ-008 memok = !dmem_req_mem | dhit; in DWAIT, memok = dhit.
REQ-009 RUN->DWAIT SHALL occur when dmem_req_mem & !dhit; DWAIT->RUN when dhit; RUN/DWAIT->HALTED when halt_wb & memok; HALTED exits only on RST.
REQ-010 !memok: enable=0, flush=0 (full freeze), regardless of ihit, branch, load-use.
REQ-011 memok & ihit, no hazard: enable all 1, flush all 0.
REQ-012 memok & !ihit: enable[0]=0, flush[0]=0, enable[L-1:1]=1, flush[1]=1 (bubble into latch 1); other flush 0.
REQ-013 Load-use = memread_ex & rd_ex!=0 & (rd_ex==rs_id | rd_ex==rt_id); when memok & load-use & !branch_mem: enable[0]=0, flush[1]=1, enable[L-1:1]=1.
REQ-014 memok & branch_mem: flush[BR_LATCH:0]=1, enable all 1; branch overrides load-use and !ihit.
REQ-015 Priority SHALL be: RST > HALTED > !memok > branch_mem > load-use > !ihit > normal.
REQ-016 HALTED: enable=0, flush=0, halt=1.
REQ-017 dhit without dmem_req_mem in RUN SHALL be ignored.
REQ-018 Outputs enable/flush SHALL be combinational from state and inputs; halt, stall_cnt registered.

Reset
REQ-019 While RST=1: enable=0, flush all 1; next state RUN, halt=0, stall_cnt=0.
REQ-020 RST mid-DWAIT or in HALTED SHALL return to RUN with no residual stall on the following cycle.

Configuration
REQ-021 Macro HAZARD_PERF_CNT_EN defined: stall_cnt increments each non-reset cycle with enable[0]=0 and state!=HALTED, saturating at all-ones.
REQ-022 Macro HAZARD_PERF_CNT_EN undefined: stall_cnt tied to 0, no counter flops.

Verification
REQ-023 dmem_req_mem=1, dhit=0 for 3 cycles then 1 -> enable=0 3 cycles, DWAIT entered, enable=all 1 on dhit cycle, RUN next.
REQ-024 memread_ex=1, rd_ex=5, rs_id=5, ihit=1 -> enable=4'b1110, flush=4'b0010 one cycle; rd_ex=0 same case -> no stall.
REQ-025 branch_mem=1 with simultaneous load-use and ihit=0 -> flush=4'b0111, enable=4'b1111.
REQ-026 halt_wb=1 with memok -> halt=1 next cycle, enable=0 thereafter until RST; RST -> halt=0, RUN.
REQ-027 HAZARD_PERF_CNT_EN on, 10 cycles ihit=0 -> stall_cnt=10; CNTW=4, 20 stall cycles -> stall_cnt=15; macro off -> stall_cnt=0.
